// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM; latches the fetched word into IR and sequences PC/RF/ALU/DMEM strobes.
// Optional macro CTRL_ILLEGAL_HALT_EN: undefined opcodes enter a sticky HALT state instead of running as a NOP.
module multicycle_ctrl #(
    parameter int OPW   = 6,
    parameter int FUNCW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             alu_zero,
    output logic [31:0]      PC_immed,
    output logic             PC_sel,
    output logic             PC_lden,
    output logic [4:0]       rs_addr,
    output logic [4:0]       rd_addr,
    output logic [4:0]       rt_addr,
    output logic             rf_b_sel,
    output logic             rf_we,
    output logic             rf_wrdata_sel,
    output logic             alu_bin_sel,
    output logic [FUNCW-1:0] alu_func,
    output logic [31:0]      imm_out,
    output logic             mem_we,
    output logic             byte_op,
    output logic             halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
`ifdef CTRL_ILLEGAL_HALT_EN
        S_BRANCH = 3'd5,
        S_HALT   = 3'd6
`else
        S_BRANCH = 3'd5
`endif
    } state_t;

    typedef enum logic [3:0] {
        OP_RTYPE, OP_LI, OP_LUI, OP_ADDI, OP_ANDI, OP_ORI,
        OP_LB, OP_LW, OP_SW, OP_B, OP_BEQ, OP_BNE, OP_UNDEF
    } op_t;

    function automatic op_t classify(input logic [OPW-1:0] opc);
        case (opc)
            6'b100000: return OP_RTYPE;
            6'b111000: return OP_LI;
            6'b111001: return OP_LUI;
            6'b110000: return OP_ADDI;
            6'b110010: return OP_ANDI;
            6'b110011: return OP_ORI;
            6'b000011: return OP_LB;
            6'b001111: return OP_LW;
            6'b011111: return OP_SW;
            6'b111111: return OP_B;
            6'b000000: return OP_BEQ;
            6'b000001: return OP_BNE;
            default:   return OP_UNDEF;
        endcase
    endfunction

    function automatic logic [FUNCW-1:0] alu_func_of(input op_t op, input logic [FUNCW-1:0] fn);
        case (op)
            OP_RTYPE: return fn;
            OP_ANDI:  return FUNCW'(2);
            OP_ORI:   return FUNCW'(3);
            default:  return FUNCW'(0);
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    op_t              op_q, op_d;

    logic             lden_q, lden_d;
    logic             rf_we_q, rf_we_d;
    logic             mem_we_q, mem_we_d;
    logic             rf_b_sel_q, rf_b_sel_d;
    logic             wrdata_sel_q, wrdata_sel_d;
    logic             bin_sel_q, bin_sel_d;
    logic             byte_op_q, byte_op_d;
    logic [FUNCW-1:0] alu_func_q, alu_func_d;
    logic             br_uncond_q, br_uncond_d;
    logic             br_eq_q, br_eq_d;
    logic             br_ne_q, br_ne_d;
`ifdef CTRL_ILLEGAL_HALT_EN
    logic             halted_q, halted_d;
`endif

    assign op_q = classify(ir_q[31 -: OPW]);
    assign op_d = classify(ir_d[31 -: OPW]);

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                ir_d = instr;
                case (classify(instr[31 -: OPW]))
                    OP_B, OP_BEQ, OP_BNE: state_d = S_BRANCH;
`ifdef CTRL_ILLEGAL_HALT_EN
                    OP_UNDEF:             state_d = S_HALT;
`else
                    OP_UNDEF:             state_d = S_BRANCH;
`endif
                    default:              state_d = S_EXEC;
                endcase
            end
            S_EXEC:   state_d = (op_q == OP_LB || op_q == OP_LW || op_q == OP_SW) ? S_MEM : S_WB;
            S_MEM:    state_d = (op_q == OP_SW) ? S_FETCH : S_WB;
            S_WB:     state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
`ifdef CTRL_ILLEGAL_HALT_EN
            S_HALT:   state_d = S_HALT;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    // Outputs are precomputed from the next state/IR so every strobe comes straight off a flop.
    always_comb begin
        lden_d       = 1'b0;
        rf_we_d      = 1'b0;
        mem_we_d     = 1'b0;
        rf_b_sel_d   = 1'b0;
        wrdata_sel_d = 1'b0;
        bin_sel_d    = 1'b0;
        byte_op_d    = 1'b0;
        alu_func_d   = '0;
        br_uncond_d  = 1'b0;
        br_eq_d      = 1'b0;
        br_ne_d      = 1'b0;
`ifdef CTRL_ILLEGAL_HALT_EN
        halted_d     = 1'b0;
`endif
        case (state_d)
            S_EXEC, S_MEM, S_WB: begin
                alu_func_d = alu_func_of(op_d, ir_d[FUNCW-1:0]);
                bin_sel_d  = (op_d != OP_RTYPE);
                rf_b_sel_d = (op_d == OP_SW);
                if (state_d == S_MEM) begin
                    mem_we_d  = (op_d == OP_SW);
                    lden_d    = (op_d == OP_SW);
                    byte_op_d = (op_d == OP_LB);
                end
                if (state_d == S_WB) begin
                    rf_we_d      = 1'b1;
                    lden_d       = 1'b1;
                    wrdata_sel_d = (op_d == OP_LB || op_d == OP_LW);
                    byte_op_d    = (op_d == OP_LB);
                end
            end
            S_BRANCH: begin
                lden_d      = 1'b1;
                rf_b_sel_d  = 1'b1;
                alu_func_d  = FUNCW'(1);
                br_uncond_d = (op_d == OP_B);
                br_eq_d     = (op_d == OP_BEQ);
                br_ne_d     = (op_d == OP_BNE);
            end
`ifdef CTRL_ILLEGAL_HALT_EN
            S_HALT: halted_d = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_FETCH;
            ir_q         <= '0;
            lden_q       <= 1'b0;
            rf_we_q      <= 1'b0;
            mem_we_q     <= 1'b0;
            rf_b_sel_q   <= 1'b0;
            wrdata_sel_q <= 1'b0;
            bin_sel_q    <= 1'b0;
            byte_op_q    <= 1'b0;
            alu_func_q   <= '0;
            br_uncond_q  <= 1'b0;
            br_eq_q      <= 1'b0;
            br_ne_q      <= 1'b0;
`ifdef CTRL_ILLEGAL_HALT_EN
            halted_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            lden_q       <= lden_d;
            rf_we_q      <= rf_we_d;
            mem_we_q     <= mem_we_d;
            rf_b_sel_q   <= rf_b_sel_d;
            wrdata_sel_q <= wrdata_sel_d;
            bin_sel_q    <= bin_sel_d;
            byte_op_q    <= byte_op_d;
            alu_func_q   <= alu_func_d;
            br_uncond_q  <= br_uncond_d;
            br_eq_q      <= br_eq_d;
            br_ne_q      <= br_ne_d;
`ifdef CTRL_ILLEGAL_HALT_EN
            halted_q     <= halted_d;
`endif
        end
    end

    // Branch flags are only set in BRANCH, so PC_sel stays low outside the PC_lden cycle.
    assign PC_sel   = br_uncond_q | (br_eq_q & alu_zero) | (br_ne_q & ~alu_zero);
    assign PC_lden  = lden_q;
    assign PC_immed = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

    always_comb begin
        case (op_q)
            OP_ANDI, OP_ORI: imm_out = {16'h0000, ir_q[15:0]};
            OP_LUI:          imm_out = {ir_q[15:0], 16'h0000};
            default:         imm_out = {{16{ir_q[15]}}, ir_q[15:0]};
        endcase
    end

    assign rs_addr       = ir_q[25:21];
    assign rd_addr       = ir_q[20:16];
    assign rt_addr       = ir_q[15:11];
    assign rf_b_sel      = rf_b_sel_q;
    assign rf_we         = rf_we_q;
    assign rf_wrdata_sel = wrdata_sel_q;
    assign alu_bin_sel   = bin_sel_q;
    assign alu_func      = alu_func_q;
    assign mem_we        = mem_we_q;
    assign byte_op       = byte_op_q;
`ifdef CTRL_ILLEGAL_HALT_EN
    assign halted        = halted_q;
`else
    assign halted        = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle strobe checks for each instruction class.
module tb_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        alu_zero;
    logic [31:0] PC_immed;
    logic        PC_sel;
    logic        PC_lden;
    logic [4:0]  rs_addr, rd_addr, rt_addr;
    logic        rf_b_sel, rf_we, rf_wrdata_sel, alu_bin_sel;
    logic [3:0]  alu_func;
    logic [31:0] imm_out;
    logic        mem_we, byte_op, halted;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .instr(instr), .alu_zero(alu_zero),
        .PC_immed(PC_immed), .PC_sel(PC_sel), .PC_lden(PC_lden),
        .rs_addr(rs_addr), .rd_addr(rd_addr), .rt_addr(rt_addr),
        .rf_b_sel(rf_b_sel), .rf_we(rf_we), .rf_wrdata_sel(rf_wrdata_sel),
        .alu_bin_sel(alu_bin_sel), .alu_func(alu_func), .imm_out(imm_out),
        .mem_we(mem_we), .byte_op(byte_op), .halted(halted)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Check the four strobes for the current cycle, then advance one cycle.
    task automatic cyc(input string tag, input logic lden, input logic sel,
                       input logic rfwe, input logic memwe);
        chk1({tag, ".PC_lden"}, PC_lden, lden);
        chk1({tag, ".PC_sel"},  PC_sel,  sel);
        chk1({tag, ".rf_we"},   rf_we,   rfwe);
        chk1({tag, ".mem_we"},  mem_we,  memwe);
        step();
    endtask

    initial begin
        reset    = 1'b1;
        instr    = 32'h0;
        alu_zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;

        chk1("rst.PC_lden", PC_lden, 1'b0);
        chk1("rst.PC_sel", PC_sel, 1'b0);
        chk1("rst.rf_we", rf_we, 1'b0);
        chk1("rst.mem_we", mem_we, 1'b0);
        chk1("rst.halted", halted, 1'b0);
        chk32("rst.alu_func", {28'd0, alu_func}, 32'd0);
        chk1("rst.alu_bin_sel", alu_bin_sel, 1'b0);
        chk1("rst.rf_b_sel", rf_b_sel, 1'b0);
        chk1("rst.rf_wrdata_sel", rf_wrdata_sel, 1'b0);

        // add interrupted by reset in WB
        reset = 1'b0;
        instr = 32'h80221810;
        cyc("addA.c1", 0, 0, 0, 0);
        cyc("addA.c2", 0, 0, 0, 0);
        cyc("addA.c3", 0, 0, 0, 0);
        chk1("addA.c4.rf_we", rf_we, 1'b1);
        chk1("addA.c4.PC_lden", PC_lden, 1'b1);
        reset = 1'b1;
        #1;
        chk1("rstWB.rf_we", rf_we, 1'b0);
        chk1("rstWB.PC_lden", PC_lden, 1'b0);
        chk1("rstWB.PC_sel", PC_sel, 1'b0);
        step();
        reset = 1'b0;

        // add r3,r1,r2 from a clean FETCH
        instr = 32'h80221810;
        cyc("add.c1", 0, 0, 0, 0);
        cyc("add.c2", 0, 0, 0, 0);
        chk32("add.c3.alu_func", {28'd0, alu_func}, 32'd0);
        chk1("add.c3.alu_bin_sel", alu_bin_sel, 1'b0);
        cyc("add.c3", 0, 0, 0, 0);
        chk32("add.c4.rs", {27'd0, rs_addr}, 32'd1);
        chk32("add.c4.rd", {27'd0, rd_addr}, 32'd2);
        chk32("add.c4.rt", {27'd0, rt_addr}, 32'd3);
        chk1("add.c4.rf_wrdata_sel", rf_wrdata_sel, 1'b0);
        cyc("add.c4", 1, 0, 1, 0);

        // ori imm=0x8001: zero-extended
        instr = {6'b110011, 5'd1, 5'd2, 16'h8001};
        cyc("ori.c1", 0, 0, 0, 0);
        cyc("ori.c2", 0, 0, 0, 0);
        chk32("ori.imm_out", imm_out, 32'h00008001);
        chk32("ori.alu_func", {28'd0, alu_func}, 32'd3);
        chk1("ori.alu_bin_sel", alu_bin_sel, 1'b1);
        cyc("ori.c3", 0, 0, 0, 0);
        cyc("ori.c4", 1, 0, 1, 0);

        // addi imm=0x8001: sign-extended
        instr = {6'b110000, 5'd1, 5'd2, 16'h8001};
        cyc("addi.c1", 0, 0, 0, 0);
        cyc("addi.c2", 0, 0, 0, 0);
        chk32("addi.imm_out", imm_out, 32'hFFFF8001);
        chk32("addi.alu_func", {28'd0, alu_func}, 32'd0);
        cyc("addi.c3", 0, 0, 0, 0);
        cyc("addi.c4", 1, 0, 1, 0);

        // andi imm=0x8001
        instr = {6'b110010, 5'd1, 5'd2, 16'h8001};
        cyc("andi.c1", 0, 0, 0, 0);
        cyc("andi.c2", 0, 0, 0, 0);
        chk32("andi.imm_out", imm_out, 32'h00008001);
        chk32("andi.alu_func", {28'd0, alu_func}, 32'd2);
        cyc("andi.c3", 0, 0, 0, 0);
        cyc("andi.c4", 1, 0, 1, 0);

        // lui 0x1234
        instr = {6'b111001, 5'd0, 5'd4, 16'h1234};
        cyc("lui.c1", 0, 0, 0, 0);
        cyc("lui.c2", 0, 0, 0, 0);
        chk32("lui.imm_out", imm_out, 32'h12340000);
        cyc("lui.c3", 0, 0, 0, 0);
        cyc("lui.c4", 1, 0, 1, 0);

        // beq imm=0xFFFF taken
        instr    = {6'b000000, 5'd1, 5'd2, 16'hFFFF};
        alu_zero = 1'b1;
        cyc("beqT.c1", 0, 0, 0, 0);
        cyc("beqT.c2", 0, 0, 0, 0);
        chk32("beqT.PC_immed", PC_immed, 32'hFFFFFFFC);
        chk32("beqT.alu_func", {28'd0, alu_func}, 32'd1);
        chk1("beqT.rf_b_sel", rf_b_sel, 1'b1);
        cyc("beqT.c3", 1, 1, 0, 0);

        // beq not taken
        alu_zero = 1'b0;
        cyc("beqN.c1", 0, 0, 0, 0);
        cyc("beqN.c2", 0, 0, 0, 0);
        cyc("beqN.c3", 1, 0, 0, 0);

        // bne with zero=0 -> taken
        instr = {6'b000001, 5'd1, 5'd2, 16'h0004};
        cyc("bne.c1", 0, 0, 0, 0);
        cyc("bne.c2", 0, 0, 0, 0);
        chk32("bne.PC_immed", PC_immed, 32'h00000010);
        cyc("bne.c3", 1, 1, 0, 0);

        // unconditional b, alu_zero irrelevant
        instr = {6'b111111, 5'd0, 5'd0, 16'h0001};
        cyc("b.c1", 0, 0, 0, 0);
        cyc("b.c2", 0, 0, 0, 0);
        cyc("b.c3", 1, 1, 0, 0);

        // lw then sw back-to-back
        instr = {6'b001111, 5'd1, 5'd5, 16'h0008};
        cyc("lw.c1", 0, 0, 0, 0);
        cyc("lw.c2", 0, 0, 0, 0);
        chk1("lw.c3.alu_bin_sel", alu_bin_sel, 1'b1);
        cyc("lw.c3", 0, 0, 0, 0);
        chk1("lw.c4.byte_op", byte_op, 1'b0);
        cyc("lw.c4", 0, 0, 0, 0);
        chk1("lw.c5.rf_wrdata_sel", rf_wrdata_sel, 1'b1);
        cyc("lw.c5", 1, 0, 1, 0);

        instr = {6'b011111, 5'd1, 5'd5, 16'h0008};
        cyc("sw.c1", 0, 0, 0, 0);
        cyc("sw.c2", 0, 0, 0, 0);
        chk1("sw.c3.rf_b_sel", rf_b_sel, 1'b1);
        cyc("sw.c3", 0, 0, 0, 0);
        chk1("sw.c4.rf_b_sel", rf_b_sel, 1'b1);
        cyc("sw.c4", 1, 0, 0, 1);

        // lb: byte_op held through MEM and WB
        instr = {6'b000011, 5'd1, 5'd6, 16'hFFFE};
        cyc("lb.c1", 0, 0, 0, 0);
        cyc("lb.c2", 0, 0, 0, 0);
        chk32("lb.imm_out", imm_out, 32'hFFFFFFFE);
        cyc("lb.c3", 0, 0, 0, 0);
        chk1("lb.c4.byte_op", byte_op, 1'b1);
        cyc("lb.c4", 0, 0, 0, 0);
        chk1("lb.c5.byte_op", byte_op, 1'b1);
        chk1("lb.c5.rf_wrdata_sel", rf_wrdata_sel, 1'b1);
        cyc("lb.c5", 1, 0, 1, 0);

        // undefined opcode 0x2A
        instr    = {6'h2A, 5'd1, 5'd2, 16'h0010};
        alu_zero = 1'b1;
        cyc("ill.c1", 0, 0, 0, 0);
        cyc("ill.c2", 0, 0, 0, 0);
`ifdef CTRL_ILLEGAL_HALT_EN
        for (int i = 0; i < 20; i++) begin
            chk1("halt.halted", halted, 1'b1);
            chk1("halt.PC_lden", PC_lden, 1'b0);
            chk1("halt.rf_we", rf_we, 1'b0);
            step();
        end
        reset = 1'b1;
        #1;
        chk1("halt.rst.halted", halted, 1'b0);
        step();
        reset = 1'b0;
`else
        chk1("ill.c3.halted", halted, 1'b0);
        cyc("ill.c3", 1, 0, 0, 0);
        cyc("ill.next", 0, 0, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM at the consuming end of the fetch interface.
- Receives `instr` from the fetch stage, whose instruction memory has a 1-cycle synchronous read.
- Drives `PC_sel`, `PC_lden` and `PC_immed` back to the fetch stage.
- Latches the instruction into an internal IR, decodes it, and sequences the register-file, ALU and data-memory controls, one instruction per 3-5 cycles.

Parameters:
- `OPW`, 6: opcode field width (`instr[31:26]`).
- `FUNCW`, 4: ALU function width (`instr[3:0]`).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `instr`  in  32  instruction word from fetch stage; valid in the cycle after FETCH.
- `alu_zero`  in  1  ALU zero flag; sampled in BRANCH.
- `PC_immed`  out  32  branch offset to fetch stage: SignExt(IR[15:0])<<2.
- `PC_sel`  out  1  1 = PC+4+`PC_immed`, 0 = PC+4.
- `PC_lden`  out  1  one-cycle PC load strobe at the end of each instruction.
- `rs_addr`  out  5  IR[25:21].
- `rd_addr`  out  5  IR[20:16].
- `rt_addr`  out  5  IR[15:11].
- `rf_b_sel`  out  1  0 = read port B uses `rt_addr`, 1 = uses `rd_addr` (sw, beq, bne).
- `rf_we`  out  1  register-file write strobe.
- `rf_wrdata_sel`  out  1  0 = ALU result, 1 = memory data.
- `alu_bin_sel`  out  1  0 = register B, 1 = `imm_out`.
- `alu_func`  out  4  ALU operation.
- `imm_out`  out  32  extended immediate.
- `mem_we`  out  1  data-memory write strobe.
- `byte_op`  out  1  1 for lb.
- `halted`  out  1  illegal-opcode halt flag (see Optional Feature).

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, BRANCH, HALT. State is registered; all outputs are decoded from state + IR (Moore).
- Reset (async):
  - state=FETCH, IR=0.
  - `PC_lden`, `PC_sel`, `rf_we`, `mem_we`, `halted` = 0.
  - `alu_func`=0, selects=0.
  - Reset mid-instruction aborts it immediately; no strobe may glitch high.
- FETCH: imem samples the current PC at the closing edge; go to DECODE.
- DECODE: IR <= `instr` at the closing edge. Next state by opcode:
  - R-type (100000), li (111000), lui (111001), addi (110000), andi (110010), ori (110011), lb (000011), lw (001111), sw (011111) -> EXEC.
  - b (111111), beq (000000), bne (000001) -> BRANCH.
  - Any other opcode -> BRANCH as NOP (`PC_sel`=0).
- Immediate extension:
  - Sign-extend: addi, li, lb, lw, sw.
  - Zero-extend: andi, ori.
  - lui: IR[15:0]<<16.
  - `PC_immed` is always SignExt<<2, with wrap-around modulo 2^32.
- `alu_func` in EXEC/MEM/WB:
  - R-type: IR[3:0].
  - addi, li, lb, lw, sw, lui: 0000 (add). li/lui use rs=0 in the encoding; the controller does not force rs.
  - andi: 0010.
  - ori: 0011.
- EXEC: `alu_bin_sel`=1 except R-type. Next state: loads/stores -> MEM; others -> WB.
- MEM:
  - sw: `mem_we`=1 and `PC_lden`=1 for this cycle, `PC_sel`=0; then FETCH.
  - lb/lw: next state WB. `byte_op`=1 for lb, held through WB.
- WB: `rf_we`=1 and `PC_lden`=1, `PC_sel`=0; `rf_wrdata_sel`=1 for loads. Then FETCH.
- BRANCH: `PC_lden`=1, `rf_b_sel`=1, ALU compares rs vs rd (`alu_func` 0001, subtract). Then FETCH.
  - b: `PC_sel`=1.
  - beq: `PC_sel`=`alu_zero`.
  - bne: `PC_sel`=~`alu_zero`.
  - NOP: `PC_sel`=0.
- Cycle counts: branch/NOP 3; ALU-type 4; sw 4; lb/lw 5.
- `PC_lden` is high for exactly one cycle per instruction. `rf_we` and `mem_we` are never high together.
- `PC_sel` is 0 whenever `PC_lden`=0.

Optional Feature:
- Macro: `CTRL_ILLEGAL_HALT_EN`.
- Defined: an undefined opcode in DECODE -> HALT.
  - HALT: all strobes 0, `halted`=1, no exit except reset.
- Undefined: undefined opcodes execute as a 3-cycle NOP; `halted` is tied 0 and the HALT state is not built.

Test Plan:
- Reset asserted mid-WB of an add -> `rf_we` and `PC_lden` drop within the same cycle; state=FETCH; after release the first `PC_lden` appears on cycle 4 of the next R-type.
- add r3,r1,r2 (0x80221810 form, func=0000) -> `rf_we`=1 only in cycle 4, `alu_func`=0000, `alu_bin_sel`=0, `PC_lden` 1 cycle, `PC_sel`=0.
- ori with imm=0x8001 -> `imm_out`=0x00008001; addi with imm=0x8001 -> `imm_out`=0xFFFF8001; lui 0x1234 -> `imm_out`=0x12340000.
- beq, imm=0xFFFF:
  - `alu_zero`=1 -> `PC_immed`=0xFFFFFFFC, `PC_sel`=1, `PC_lden`=1 in cycle 3.
  - `alu_zero`=0 -> `PC_sel`=0.
- lw then sw back-to-back:
  - lw: 5 cycles, `rf_wrdata_sel`=1 in WB.
  - sw: `mem_we`=1 in cycle 4 only, `rf_we` never high, `rf_b_sel`=1.
- Opcode 0x2A:
  - Without macro: 3-cycle NOP with `PC_sel`=0.
  - With `CTRL_ILLEGAL_HALT_EN`: `halted`=1 and no `PC_lden` for 20 cycles; reset clears `halted`.
